// File: rtl/tree_compare_pkg.sv
// rtl/tree_compare_pkg.sv - shared types and lane packing helper for the compare tree and broadcast distributor
//
// Purpose: the one place that fixes the transaction state encoding and the
// bit layout of packed per-channel buses (channel i at [i*W +: W]). The
// broadcast distributor and the min-reduction compare tree both use it, so
// they always agree on which bits belong to which channel.
// Ports: none (package).

package tree_compare_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH    = 8;
  localparam int unsigned DEFAULT_CHANNEL_COUNT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tb_state_t;

  // LSB position of a lane inside a packed DATA_WIDTH*CHANNEL_COUNT bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/broadcast_lane.sv
// rtl/broadcast_lane.sv - one output channel of the tree broadcast distributor
//
// Purpose: holds the value and pending bit for a single neighbour channel and
// retires the pending bit on its valid/ready handshake. With
// TREE_BROADCAST_SKIP_UNCHANGED_EN defined it also remembers the last value
// delivered, so a repeat of that value is not sent again.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   load          transaction accepted this cycle (latch value, arm pending)
//   mask_bit      channel is connected (only looked at on load)
//   in_value      value offered by upstream
//   out_ready     channel ready
//   out_value     latched value for this channel
//   out_valid     channel valid (pending and not yet handshaken)
//   pending_next  pending bit after this cycle's update, for the top's zero check

module broadcast_lane
  import tree_compare_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  mask_bit,
  input  logic [DATA_WIDTH-1:0] in_value,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic                  out_valid,
  output logic                  pending_next
);

  logic                  pending_q;
  logic                  pending_d;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  handshake;
  logic                  unchanged;

  // pending is only ever set on load, so a lane that has handshaken stays
  // quiet for the rest of the transaction. Readys on idle lanes do nothing.
  assign handshake = pending_q & out_ready;

`ifdef TREE_BROADCAST_SKIP_UNCHANGED_EN
  logic [DATA_WIDTH-1:0] last_sent_q;
  logic                  sent_ok_q;

  // sent_ok guards against matching the reset value of last_sent before the
  // lane has ever delivered anything.
  assign unchanged = sent_ok_q && (last_sent_q == in_value);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_sent_q <= '0;
      sent_ok_q   <= 1'b0;
    end else if (handshake) begin
      last_sent_q <= value_q;
      sent_ok_q   <= 1'b1;
    end
  end
`else
  assign unchanged = 1'b0;
`endif

  always_comb begin
    pending_d = pending_q;
    if (load) begin
      pending_d = mask_bit & ~unchanged;
    end else if (handshake) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      value_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (load) begin
        value_q <= in_value;
      end
    end
  end

  assign out_value    = value_q;
  assign out_valid    = pending_q;
  assign pending_next = pending_d;

endmodule

// File: rtl/tree_broadcast_distributor.sv
// rtl/tree_broadcast_distributor.sv - fan one resolved value out to up to CHANNEL_COUNT neighbour channels
//
// Purpose: accepts one value per transaction, presents it on every connected
// channel with an independent valid/ready handshake, and pulses done once all
// targeted channels have taken it. Sits between the local solver result and
// the per-channel link drivers.
// Optional feature: TREE_BROADCAST_SKIP_UNCHANGED_EN skips channels whose last
// delivered value equals the new one.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   in_value      value to distribute
//   in_valid      upstream offers in_value
//   in_ready      idle and out of reset, can accept
//   channel_mask  connected channels, sampled on accept
//   out_values    channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valids    per-channel valid
//   out_readys    per-channel ready
//   busy          transaction in flight
//   done          one-cycle pulse when every targeted channel has handshaken

module tree_broadcast_distributor
  import tree_compare_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int CHANNEL_COUNT = DEFAULT_CHANNEL_COUNT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            in_value,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHANNEL_COUNT-1:0]         channel_mask,
  output logic [DATA_WIDTH*CHANNEL_COUNT-1:0] out_values,
  output logic [CHANNEL_COUNT-1:0]         out_valids,
  input  logic [CHANNEL_COUNT-1:0]         out_readys,
  output logic                             busy,
  output logic                             done
);

  tb_state_t                state_q;
  logic                     done_q;
  logic                     busy_q;
  logic                     accept;
  logic [CHANNEL_COUNT-1:0] pending_next;
  logic                     all_clear;

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  // Covers both the accept cycle (empty or fully skipped mask) and SEND
  // (every remaining lane handshaking this cycle).
  assign all_clear = ~|pending_next;

  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_lane
    broadcast_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .load        (accept),
      .mask_bit    (channel_mask[i]),
      .in_value    (in_value),
      .out_ready   (out_readys[i]),
      .out_value   (out_values[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .out_valid   (out_valids[i]),
      .pending_next(pending_next[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (all_clear) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (all_clear) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_tree_broadcast_distributor.sv
// tb/tb_tree_broadcast_distributor.sv - directed self-checking bench for tree_broadcast_distributor

module tb_tree_broadcast_distributor;

  localparam int DW = 8;
  localparam int CC = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     in_value;
  logic              in_valid;
  logic              in_ready;
  logic [CC-1:0]     channel_mask;
  logic [DW*CC-1:0]  out_values;
  logic [CC-1:0]     out_valids;
  logic [CC-1:0]     out_readys;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  // Staggered-ready table, indexed by cycle after accept (1..7).
  logic [CC-1:0] stag_exp_v [1:7] = '{5'b10101, 5'b10101, 5'b10100, 5'b10100,
                                      5'b00100, 5'b00100, 5'b00000};
  logic [CC-1:0] stag_rdy   [1:7] = '{5'b00010, 5'b00011, 5'b00010, 5'b10010,
                                      5'b00010, 5'b00110, 5'b00010};

  tree_broadcast_distributor #(.DATA_WIDTH(DW), .CHANNEL_COUNT(CC)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_value    (in_value),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .channel_mask(channel_mask),
    .out_values  (out_values),
    .out_valids  (out_valids),
    .out_readys  (out_readys),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_value = '0; in_valid = 1'b0; channel_mask = '0; out_readys = '0;

    // Reset then idle
    tick(); tick();
    check("rst_in_ready_low", 64'(in_ready), 64'd0);
    reset = 1'b0; #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_valids", 64'(out_valids), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_values", 64'(out_values), 64'd0);

    // Full broadcast
    in_value = 8'h22; channel_mask = 5'b11111; in_valid = 1'b1; out_readys = 5'b11111;
    tick(); in_valid = 1'b0;
    check("full_valids", 64'(out_valids), 64'h1F);
    check("full_values", 64'(out_values), 64'h22_22_22_22_22);
    check("full_busy", 64'(busy), 64'd1);
    check("full_in_ready_low", 64'(in_ready), 64'd0);
    check("full_done_early", 64'(done), 64'd0);
    tick();
    check("full_done", 64'(done), 64'd1);
    check("full_valids_off", 64'(out_valids), 64'd0);
    tick();
    check("full_in_ready_back", 64'(in_ready), 64'd1);
    check("full_done_once", 64'(done), 64'd0);
    check("full_busy_off", 64'(busy), 64'd0);

    // Staggered readys; bit 1 ready held high on an untargeted lane
    in_value = 8'h11; channel_mask = 5'b10101; in_valid = 1'b1; out_readys = '0;
    tick(); in_valid = 1'b0; channel_mask = 5'b01010;
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("stag_valids_c%0d", c), 64'(out_valids), 64'(stag_exp_v[c]));
      check($sformatf("stag_done_c%0d", c), 64'(done), (c == 7) ? 64'd1 : 64'd0);
      check($sformatf("stag_values_c%0d", c), 64'(out_values), 64'h11_11_11_11_11);
      out_readys = stag_rdy[c];
      tick();
    end
    out_readys = '0;
    check("stag_done_after", 64'(done), 64'd0);
    check("stag_in_ready", 64'(in_ready), 64'd1);

    // Empty mask
    in_value = 8'h88; channel_mask = 5'b00000; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    check("empty_valids", 64'(out_valids), 64'd0);
    check("empty_done", 64'(done), 64'd1);
    check("empty_values", 64'(out_values), 64'h88_88_88_88_88);
    tick();
    check("empty_done_once", 64'(done), 64'd0);
    check("empty_in_ready", 64'(in_ready), 64'd1);

    // Reset mid-SEND
    in_value = 8'h5A; channel_mask = 5'b00011; in_valid = 1'b1; out_readys = '0;
    tick(); in_valid = 1'b0;
    check("rmid_valids", 64'(out_valids), 64'h03);
    tick();
    check("rmid_stall", 64'(out_valids), 64'h03);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("rmid_valids_clr", 64'(out_valids), 64'd0);
    check("rmid_values_clr", 64'(out_values), 64'd0);
    check("rmid_done", 64'(done), 64'd0);
    check("rmid_busy", 64'(busy), 64'd0);
    check("rmid_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("rmid_no_done", 64'(done), 64'd0);

    // Repeat-value sends
    in_value = 8'hFB; channel_mask = 5'b11111; in_valid = 1'b1; out_readys = 5'b11111;
    tick(); in_valid = 1'b0;
    check("rep1_valids", 64'(out_valids), 64'h1F);
    tick(); tick();
    check("rep1_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
`ifdef TREE_BROADCAST_SKIP_UNCHANGED_EN
    check("rep2_valids", 64'(out_valids), 64'd0);
    check("rep2_done", 64'(done), 64'd1);
`else
    check("rep2_valids", 64'(out_valids), 64'h1F);
    check("rep2_done", 64'(done), 64'd0);
`endif
    tick(); tick();
    check("rep2_in_ready", 64'(in_ready), 64'd1);
    in_value = 8'hFC; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    check("rep3_valids", 64'(out_valids), 64'h1F);
    check("rep3_values", 64'(out_values), 64'hFC_FC_FC_FC_FC);
    tick();
    check("rep3_done", 64'(done), 64'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
